// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults and rounding/saturation constants for the FFT twiddle path
package fft_pkg;
  localparam int DEF_WIDTH = 12;
  localparam int DEF_FRAC_BITS = 10;
  localparam int DEF_CNT_W = 16;
  localparam int SAT_MAX = (1 << (DEF_WIDTH - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DEF_WIDTH - 1));
  localparam int ROUND_K = 1 << (DEF_FRAC_BITS - 1);
endpackage

// File: rtl/cmul_round_stage_round_sat.sv
// round_sat: round-half-up by FRAC_BITS then clamp a 2*WIDTH+1 bit sum to WIDTH bits
module round_sat
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic signed [2*WIDTH:0]  x,
  output logic signed [WIDTH-1:0]  y,
  output logic                     sat
);
  // one guard bit so adding the rounding constant to the largest sum cannot wrap
  localparam int SW = 2*WIDTH + 2;
  localparam logic signed [SW-1:0] RND = SW'(1 << (FRAC_BITS - 1));
  localparam logic signed [SW-1:0] MAX = SW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] MIN = ~MAX;
  logic signed [SW-1:0] s, t;
  logic hi, lo;
  always_comb begin
    s = {x[2*WIDTH], x} + RND;
    t = s >>> FRAC_BITS;
    hi = t > MAX;
    lo = t < MIN;
    y = hi ? MAX[WIDTH-1:0] : lo ? MIN[WIDTH-1:0] : t[WIDTH-1:0];
    sat = hi | lo;
  end
endmodule

// File: rtl/cmul_round_stage.sv
// cmul_round_stage: combine complex partial products, round and saturate, two-stage valid/ready pipe
module cmul_round_stage
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [2*WIDTH-1:0] p_rr,
  input  logic signed [2*WIDTH-1:0] p_ii,
  input  logic signed [2*WIDTH-1:0] p_ri,
  input  logic signed [2*WIDTH-1:0] p_ir,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   out_re,
  output logic signed [WIDTH-1:0]   out_im,
  output logic [1:0]                out_ovf,
  output logic                      ovf_sticky,
  output logic [CNT_W-1:0]          sat_count
);
  localparam int PW = 2*WIDTH;
  logic s1_valid, s2_load, sat_re, sat_im;
  logic [PW:0] s1_re, s1_im;
  logic signed [WIDTH-1:0] rs_re, rs_im;
  always_comb begin
    s2_load = !out_valid || out_ready;
    in_ready = !s1_valid || s2_load;
  end
  round_sat #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_re (.x(s1_re), .y(rs_re), .sat(sat_re));
  round_sat #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_im (.x(s1_im), .y(rs_im), .sat(sat_im));
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_re <= '0;
      s1_im <= '0;
      out_valid <= 1'b0;
      out_re <= '0;
      out_im <= '0;
      out_ovf <= '0;
      ovf_sticky <= 1'b0;
      sat_count <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_re <= {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
          s1_im <= {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_re <= rs_re;
          out_im <= rs_im;
          out_ovf <= {sat_im, sat_re};
        end
      end
      // saturation is accounted when the sample actually leaves, not when it lands in S2
      if (out_valid && out_ready && |out_ovf) begin
        ovf_sticky <= 1'b1;
        sat_count <= &sat_count ? sat_count : sat_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cmul_round_stage.sv
// tb_cmul_round_stage: scoreboard bench, directed vectors plus random valid/ready traffic
module tb_cmul_round_stage;
  localparam int W = 12;
  localparam int F = 10;
  localparam int C = 16;
  localparam int MAXV = (1 << (W - 1)) - 1;
  typedef struct packed {
    logic [1:0]   ovf;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } res_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, ovf_sticky;
  logic signed [2*W-1:0] p_rr = 0, p_ii = 0, p_ri = 0, p_ir = 0;
  logic [W-1:0] out_re, out_im;
  logic [1:0] out_ovf;
  logic [C-1:0] sat_count;
  res_t q[$];
  res_t prev;
  int checks = 0, passed = 0, exp_sat = 0;
  bit rnd_ready = 0, push_en = 1, stalled = 0;

  always #5 clk = ~clk;

  cmul_round_stage #(.WIDTH(W), .FRAC_BITS(F), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p_rr(p_rr), .p_ii(p_ii), .p_ri(p_ri), .p_ir(p_ir),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .sat_count(sat_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic res_t mk(input logic [1:0] o, input int re, input int im);
    res_t r;
    r.ovf = o;
    r.re = re[W-1:0];
    r.im = im[W-1:0];
    return r;
  endfunction

  function automatic logic [W:0] rsat(input longint x);
    longint t;
    t = (x + (longint'(1) <<< (F - 1))) >>> F;
    if (t > MAXV) return {1'b1, W'(MAXV)};
    if (t < -MAXV - 1) return {1'b1, W'(-MAXV - 1)};
    return {1'b0, W'(t)};
  endfunction

  function automatic res_t mdl(input longint rr, ii, ri, ir);
    logic [W:0] a, b;
    res_t r;
    a = rsat(rr - ii);
    b = rsat(ri + ir);
    r.ovf = {b[W], a[W]};
    r.re = a[W-1:0];
    r.im = b[W-1:0];
    return r;
  endfunction

  task automatic send(input longint rr, ii, ri, ir, input res_t e);
    int n = 0;
    @(negedge clk);
    in_valid = 1;
    p_rr = 24'(rr);
    p_ii = 24'(ii);
    p_ri = 24'(ri);
    p_ir = 24'(ir);
    #1;
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      #1;
    end
    if (push_en) q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) if (rnd_ready) out_ready = ($urandom % 3) != 0;

  // monitor: a handshake seen here completes on the following rising edge
  always @(negedge clk) begin
    res_t e;
    #3;
    if (rst) begin
      stalled = 0;
      exp_sat = 0;
    end else begin
      if (stalled) chk("stall_stable", {out_ovf, out_re, out_im}, prev);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_re", out_re, e.re);
          chk("out_im", out_im, e.im);
          chk("out_ovf", out_ovf, e.ovf);
          if (e.ovf != 0) exp_sat++;
        end
      end
      stalled = out_valid && !out_ready;
      prev = {out_ovf, out_re, out_im};
    end
  end

  initial begin
    logic signed [2*W-1:0] r0, r1, r2, r3;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_ovf, out_re, out_im}, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_count", sat_count, 0);
    out_ready = 1;
    // unity twiddle and rounding
    send(524288, 0, 0, -262144, mk(2'b00, 512, -256));
    send(1536, 0, 0, 0, mk(2'b00, 2, 0));
    send(-1536, 0, 0, 0, mk(2'b00, -1, 0));
    send(511, 0, 0, 0, mk(2'b00, 0, 0));
    send(512, 0, 0, 0, mk(2'b00, 1, 0));
    // saturation on both rails
    send(2096128, -2097152, -2097152, -2097152, mk(2'b11, 2047, -2048));
    drain();
    chk("sticky_after_sat", ovf_sticky, 1);
    chk("count_after_sat", sat_count, 1);
    // clamp boundaries and extreme products
    send(2096128, 0, 0, 0, mk(2'b00, 2047, 0));
    send(2096640, 0, 0, 0, mk(2'b01, 2047, 0));
    send(-2097152, 0, 0, 0, mk(2'b00, -2048, 0));
    send(-2097665, 0, 0, 0, mk(2'b01, -2048, 0));
    send(0, 0, 2096640, 0, mk(2'b10, 0, 2047));
    send(-8388608, 8388607, 0, 0, mk(2'b01, -2048, 0));
    send(8388607, -8388608, -8388608, -8388608, mk(2'b11, 2047, -2048));
    drain();
    // backpressure: ramp while the output is blocked
    out_ready = 0;
    fork
      for (int k = 1; k <= 8; k++) send(k * 1024, 0, -k * 1024, 0, mk(2'b00, k, -k));
    join_none
    repeat (5) @(negedge clk);
    #2;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(negedge clk);
    out_ready = 1;
    wait fork;
    drain();
    // random traffic against the reference model
    rnd_ready = 1;
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r0 = 24'($urandom);
      r1 = 24'($urandom);
      r2 = ($urandom % 2) ? 24'($urandom) : 24'($urandom % 4096);
      r3 = ($urandom % 2) ? 24'($urandom) : 24'($urandom % 4096);
      send(r0, r1, r2, r3, mdl(r0, r1, r2, r3));
    end
    drain();
    rnd_ready = 0;
    chk("rnd_count", sat_count, exp_sat);
    chk("rnd_sticky", ovf_sticky, 1);
    // reset with two samples in flight
    @(negedge clk);
    out_ready = 0;
    push_en = 0;
    send(524288, 0, 0, 0, mk(2'b00, 512, 0));
    send(3 * 1024, 0, 0, 0, mk(2'b00, 3, 0));
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", sat_count, 0);
    chk("mid_rst_sticky", ovf_sticky, 0);
    rst = 0;
    out_ready = 1;
    push_en = 1;
    repeat (10) @(negedge clk);
    #4;
    chk("post_rst_idle", out_valid, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
